serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_sum1bcc.sv | 26 ++
 rtl/serial_adder.sv | 145 ++++++++++++++
 tb/tb_serial_adder.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder_pkg
//  Description : Shared definitions for the bit-serial adder: FSM state
//                encodings and the default operand width.
//  Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    // Default operand / result width in bits
    localparam int c_default_width = 4;

    // Controller states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage : serial_adder_pkg
`default_nettype wire

// File: rtl/serial_adder_sum1bcc.sv
`default_nettype none
// ============================================================================
//  Module      : sum1bcc
//  Description : One-bit full adder slice.
//  Ports       : x, y  - operand bits
//                c     - carry in
//                out   - sum bit
//                z     - carry out
//  Revision    : 1.0 - initial release
// ============================================================================
module sum1bcc (
    input  logic x,
    input  logic y,
    input  logic c,
    output logic out,
    output logic z
);

    logic w_p;

    assign w_p = x ^ y;
    assign out = w_p ^ c;
    assign z   = (x & y) | (c & w_p);

endmodule : sum1bcc
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : serial_adder
//  Description : Bit-serial adder. Operands are loaded on start, then one bit
//                per cycle is added LSB-first through a single full-adder
//                slice. After WIDTH cycles the result appears on sum/cout
//                with a one-cycle done pulse. sum/cout hold until the next
//                completed operation.
//  Config      : SERIAL_ADDER_SUB_EN - when defined, start with sub=1
//                computes a - b (cout=1 means no borrow). When undefined the
//                sub input is ignored.
//  Ports       : clk   - clock, rising edge
//                rst   - asynchronous active-high reset
//                start - begin one operation (accepted in IDLE only)
//                a, b  - unsigned operands
//                sub   - subtract request, sampled with start
//                busy  - operation in progress (SHIFT or DONE)
//                done  - one-cycle pulse when sum/cout are updated
//                sum   - registered result, modulo 2^WIDTH
//                cout  - registered carry-out of bit WIDTH
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_carry;

    logic             w_y;
    logic             w_cin_init;
    logic             w_s;
    logic             w_z;
    logic [WIDTH-1:0] w_res_next;

`ifdef SERIAL_ADDER_SUB_EN
    logic             r_sub;

    // Subtraction as a + ~b + 1: invert b per bit and seed the carry with 1
    assign w_y        = r_b[0] ^ r_sub;
    assign w_cin_init = sub;
`else
    logic             w_unused_sub;

    assign w_unused_sub = sub;
    assign w_y          = r_b[0];
    assign w_cin_init   = 1'b0;
`endif

    sum1bcc u_slice (
        .x   (r_a[0]),
        .y   (w_y),
        .c   (r_carry),
        .out (w_s),
        .z   (w_z)
    );

    // Sum bits enter at the MSB so that after WIDTH shifts bit 0 sits at LSB
    assign w_res_next = {w_s, r_res[WIDTH-1:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_res   <= '0;
                        r_cnt   <= '0;
                        r_carry <= w_cin_init;
`ifdef SERIAL_ADDER_SUB_EN
                        r_sub   <= sub;
`endif
                        busy    <= 1'b1;
                        r_state <= SHIFT;
                    end
                end

                SHIFT: begin
                    r_carry <= w_z;
                    r_res   <= w_res_next;
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == c_last) begin
                        // Final bit is captured straight from the slice
                        sum     <= w_res_next;
                        cout    <= w_z;
                        done    <= 1'b1;
                        r_state <= DONE;
                    end
                end

                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : serial_adder
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_serial_adder
//  Description : Self-checking bench for serial_adder (WIDTH=4). Expected
//                results come from plain integer arithmetic on the operands.
//  Config      : SERIAL_ADDER_SUB_EN - selects subtract expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

    localparam int WIDTH = 4;
    localparam int MODV  = 1 << WIDTH;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;

    int total;
    int bad;

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .sub   (sub),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference: returns {cout,sum} as an integer in 0..2*MODV-1
    function automatic int model(input int ai, input int bi, input int si);
        int t;
`ifdef SERIAL_ADDER_SUB_EN
        if (si != 0) t = ai + (MODV - bi);
        else         t = ai + bi;
`else
        t = ai + bi + (si - si);
`endif
        return t % (2 * MODV);
    endfunction

    // Call just after a falling edge. Launches one operation, optionally
    // re-asserts start with 1+1 at sample restart_at, then watches a fixed
    // window of cycles and checks latency, busy length, pulse count, result.
    task automatic do_op(input int ai, input int bi, input int si,
                         input int restart_at, input string tag);
        int exp_v;
        int done_at;
        int busy_cnt;
        int pulses;
        int got_sum;
        int got_cout;
        exp_v    = model(ai, bi, si);
        done_at  = -1;
        busy_cnt = 0;
        pulses   = 0;
        got_sum  = -1;
        got_cout = -1;
        a     = WIDTH'(ai);
        b     = WIDTH'(bi);
        sub   = si[0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int s = 0; s < WIDTH + 4; s++) begin
            if (busy) busy_cnt++;
            if (done) begin
                pulses++;
                if (done_at < 0) begin
                    done_at  = s;
                    got_sum  = int'(sum);
                    got_cout = int'(cout);
                end
            end
            if (s == restart_at) begin
                a     = WIDTH'(1);
                b     = WIDTH'(1);
                sub   = 1'b0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, " latency"}, done_at, WIDTH);
        chk({tag, " busy_cycles"}, busy_cnt, WIDTH + 1);
        chk({tag, " done_pulses"}, pulses, 1);
        chk({tag, " sum"}, got_sum, exp_v % MODV);
        chk({tag, " cout"}, got_cout, exp_v / MODV);
    endtask

    initial begin
        int seen_done;
        int ra;
        int rb;
        int rs;
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        sub   = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset busy", int'(busy), 0);
        chk("reset done", int'(done), 0);
        chk("reset sum", int'(sum), 0);
        chk("reset cout", int'(cout), 0);
        rst = 1'b0;

        // Directed cases
        do_op(3, 5, 0, -1, "add_3_5");
        do_op(15, 1, 0, -1, "add_15_1");
        do_op(15, 15, 0, -1, "add_15_15");

        // Result holds while idle
        repeat (3) @(negedge clk);
        chk("hold sum", int'(sum), 14);
        chk("hold cout", int'(cout), 1);
        chk("hold busy", int'(busy), 0);

        // start during SHIFT is ignored
        do_op(3, 5, 0, 1, "restart_ignored");

        // Reset in the middle of an operation
        a     = WIDTH'(3);
        b     = WIDTH'(5);
        sub   = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        chk("abort sum", int'(sum), 0);
        chk("abort cout", int'(cout), 0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int s = 0; s < WIDTH + 3; s++) begin
            if (done || busy) seen_done++;
            @(negedge clk);
        end
        chk("abort no_activity", seen_done, 0);

        // start accepted at the first edge after reset release
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_op(2, 2, 0, -1, "after_rst_2_2");

`ifdef SERIAL_ADDER_SUB_EN
        do_op(5, 3, 1, -1, "sub_5_3");
        chk("sub_5_3 direct_sum", int'(sum), 2);
        chk("sub_5_3 direct_cout", int'(cout), 1);
        do_op(3, 5, 1, -1, "sub_3_5");
        chk("sub_3_5 direct_sum", int'(sum), 14);
        chk("sub_3_5 direct_cout", int'(cout), 0);
`else
        do_op(5, 3, 1, -1, "sub_ignored_5_3");
        chk("sub_ignored direct_sum", int'(sum), 8);
        chk("sub_ignored direct_cout", int'(cout), 0);
`endif

        // Exhaustive add sweep
        for (int i = 0; i < MODV; i++) begin
            for (int j = 0; j < MODV; j++) begin
                do_op(i, j, 0, -1, "sweep");
            end
        end

        // Randomized operations, sub included
        for (int k = 0; k < 40; k++) begin
            ra = int'($urandom_range(MODV - 1, 0));
            rb = int'($urandom_range(MODV - 1, 0));
            rs = int'($urandom_range(1, 0));
            do_op(ra, rb, rs, -1, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder
`default_nettype wire
